// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction-fetch sequencing FSM.
//
// Issues one read request at a time to instruction memory, waits for the
// data, and tells the PC/decode logic what to do with it. Redirects (taken
// branches/jumps) squash an in-flight fetch. Decode back-pressure parks the
// fetched instruction in HOLD. A HALT instruction parks the machine in
// HALTED, which fires a single memory-dump pulse.
//
// Optional build macro:
//   FETCH_CTRL_TIMEOUT_EN  - bound the time spent in WAIT/DROP to
//                            TIMEOUT_CYCLES cycles. On expiry, raise the sticky
//                            err flag and enter HALTED. When the macro is
//                            undefined, err is tied low and memory may take
//                            arbitrarily long.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum WAIT/DROP residency before a timeout
//                   (only meaningful with FETCH_CTRL_TIMEOUT_EN)
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   mem_done      in   instruction memory returns data this cycle
//   redirect      in   branch/jump taken; PC source is the target path
//   hazard_stall  in   decode cannot accept an instruction this cycle
//   halt_dec      in   the currently valid instruction is HALT
//   mem_rd        out  one-cycle read-request strobe (pure Moore)
//   PCWriteEn     out  PC register write enable
//   isNop         out  select stall PC and inject a bubble into decode
//   instr_valid   out  fetched instruction is valid to decode
//   dump          out  one-cycle memory-dump pulse on entry to HALTED
//   err           out  sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_done,
    input  logic redirect,
    input  logic hazard_stall,
    input  logic halt_dec,
    output logic mem_rd,
    output logic PCWriteEn,
    output logic isNop,
    output logic instr_valid,
    output logic dump,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DROP   = 3'd3,
        S_HOLD   = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t state;
    state_t state_nx;

    // Set after the first cycle spent in HALTED, so dump fires only once.
    logic halt_seen;

    // Asserted on the last permitted WAIT/DROP cycle with no data returned.
    logic timeout_hit;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge and process order is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            halt_seen <= 1'b0;
        end else begin
            state     <= state_nx;
            halt_seen <= (state == S_HALTED);
        end
    end

    // -----------------------------------------------------------------------
    // Optional fetch timeout
    // -----------------------------------------------------------------------
`ifdef FETCH_CTRL_TIMEOUT_EN
    // The counter only has to reach TIMEOUT_CYCLES-1; the fire condition
    // leaves WAIT/DROP, which clears the counter before it can wrap.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             waiting;
    logic             waiting_nx;

    assign waiting     = (state == S_WAIT) || (state == S_DROP);
    assign waiting_nx  = (state_nx == S_WAIT) || (state_nx == S_DROP);
    assign timeout_hit = waiting && !mem_done &&
                         (int'(wait_cnt) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            // WAIT->DROP keeps counting: the same request is still overdue.
            if (waiting && waiting_nx) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;

    // TIMEOUT_CYCLES has no function in this build; keep it referenced so the
    // parameter list stays identical between both builds.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    // mem_rd depends on state alone. The other outputs are qualified by the
    // registered state, so none of them can assert from IDLE or REQ.
    always_comb begin
        // NOTE: next state and every output get a default before the case,
        // so no branch leaves a value unassigned and no latch is inferred.
        state_nx    = state;
        mem_rd      = 1'b0;
        PCWriteEn   = 1'b0;
        isNop       = 1'b0;
        instr_valid = 1'b0;
        dump        = 1'b0;

        unique case (state)
            S_IDLE: begin
                state_nx = S_REQ;
            end

            // One request strobe. A redirect this cycle means the returning
            // data belongs to the old path, so wait for it in DROP.
            S_REQ: begin
                mem_rd   = 1'b1;
                state_nx = redirect ? S_DROP : S_WAIT;
            end

            S_WAIT: begin
                if (redirect) begin
                    if (mem_done) begin
                        // Data and redirect in the same cycle: discard the data
                        // immediately, exactly as DROP would.
                        PCWriteEn = 1'b1;
                        isNop     = 1'b1;
                        state_nx  = S_REQ;
                    end else begin
                        state_nx = S_DROP;
                    end
                end else if (mem_done) begin
                    instr_valid = 1'b1;
                    if (halt_dec) begin
                        state_nx = S_HALTED;
                    end else if (hazard_stall) begin
                        state_nx = S_HOLD;
                    end else begin
                        PCWriteEn = 1'b1;
                        state_nx  = S_REQ;
                    end
                end
            end

            // Wait for the squashed fetch to complete so that only one request
            // is ever outstanding, then bubble decode and take the new PC.
            S_DROP: begin
                if (mem_done) begin
                    PCWriteEn = 1'b1;
                    isNop     = 1'b1;
                    state_nx  = S_REQ;
                end
            end

            // The instruction stays presented until decode takes it. A
            // redirect wins over both halt and stall.
            S_HOLD: begin
                if (redirect) begin
                    PCWriteEn = 1'b1;
                    isNop     = 1'b1;
                    state_nx  = S_REQ;
                end else begin
                    instr_valid = 1'b1;
                    if (halt_dec) begin
                        state_nx = S_HALTED;
                    end else if (!hazard_stall) begin
                        PCWriteEn = 1'b1;
                        state_nx  = S_REQ;
                    end
                end
            end

            // Terminal until reset; dump only on the entry cycle.
            S_HALTED: begin
                dump = !halt_seen;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Timeout overrides any WAIT/DROP transition. Outputs are already 0
        // whenever it can fire, because mem_done is low.
        if (timeout_hit) begin
            state_nx = S_HALTED;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the max WAIT/DROP cycles before a timeout error (used only under FETCH_CTRL_TIMEOUT_EN).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_done  in  1  instruction memory has returned data this cycle.
REQ-005 redirect  in  1  branch/jump taken; PC source is sum2/jr path this cycle.
REQ-006 hazard_stall  in  1  decode cannot accept an instruction this cycle.
REQ-007 halt_dec  in  1  the currently valid instruction is HALT.
REQ-008 mem_rd  out  1  one-cycle read-request strobe to instruction memory.
REQ-009 PCWriteEn  out  1  PC register write enable.
REQ-010 isNop  out  1  select stall PC and inject a bubble into decode.
REQ-011 instr_valid  out  1  fetched instruction is valid to decode.
REQ-012 dump  out  1  one-cycle memory-dump pulse.
REQ-013 err  out  1  sticky fetch-timeout flag.

Function
REQ-014 States SHALL be IDLE, REQ, WAIT, DROP, HOLD, HALTED; all outputs SHALL be Moore or registered-state-qualified, with no combinational path from inputs to mem_rd.
REQ-015 IDLE SHALL go to REQ on the next cycle; all outputs 0.
REQ-016 REQ SHALL assert mem_rd=1 for exactly one cycle and go to WAIT; redirect in REQ SHALL go to DROP instead.
REQ-017 WAIT, mem_done=0, redirect=0: remain in WAIT, all outputs 0.
REQ-018 WAIT, redirect=1 (any mem_done): go to DROP; if mem_done=1 same cycle, treat the data as dropped and apply REQ-020 that cycle.
REQ-019 WAIT, mem_done=1, redirect=0: instr_valid=1; if hazard_stall=0 and halt_dec=0, PCWriteEn=1 and go to REQ; if hazard_stall=1, go to HOLD with PCWriteEn=0.
REQ-020 DROP, mem_done=1: PCWriteEn=1, isNop=1, instr_valid=0, go to REQ; mem_done=0: stay in DROP, outputs 0.
REQ-021 HOLD: instr_valid=1 and PCWriteEn=0 while hazard_stall=1; when hazard_stall falls, PCWriteEn=1 and go to REQ; redirect in HOLD: isNop=1, PCWriteEn=1, go to REQ.
REQ-022 Any state with instr_valid=1 and halt_dec=1 and redirect=0 SHALL go to HALTED with PCWriteEn=0.
REQ-023 HALTED SHALL assert dump=1 on its first cycle only, then hold all outputs 0 until rst.
REQ-024 At most one mem_rd SHALL be outstanding; mem_rd SHALL NOT assert in WAIT, DROP, HOLD, or HALTED.
REQ-025 mem_done seen in IDLE, REQ, HOLD, or HALTED SHALL be ignored.
REQ-026 Minimum fetch latency SHALL be 2 cycles, mem_rd to instr_valid (REQ then WAIT with mem_done).

Reset
REQ-027 rst=1 SHALL force IDLE and clear the timeout counter and err on the next edge, from any state including mid-WAIT or DROP.
REQ-028 During and after reset, mem_rd, PCWriteEn, isNop, instr_valid, dump, and err SHALL read 0 until the FSM leaves IDLE.

Configuration
REQ-029 With FETCH_CTRL_TIMEOUT_EN defined, a counter SHALL increment each cycle in WAIT/DROP, clear on leaving them, and at TIMEOUT_CYCLES without mem_done set err=1 (sticky) and go to HALTED.
REQ-030 Without FETCH_CTRL_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied 0, and WAIT/DROP SHALL wait indefinitely.

Verification
REQ-031 rst for 2 cycles, then mem_done on 1st WAIT cycle each fetch -> mem_rd at cycles 1,3,5; instr_valid+PCWriteEn at cycles 2,4,6.
REQ-032 mem_done delayed 3 cycles -> WAIT held 3 cycles, no second mem_rd, then instr_valid=1 for one cycle.
REQ-033 redirect in 2nd WAIT cycle, mem_done 2 cycles later -> DROP; on done, isNop=1, PCWriteEn=1, instr_valid=0, then mem_rd next cycle.
REQ-034 hazard_stall high 4 cycles at done -> instr_valid high 4+1 cycles, PCWriteEn=0 for 4, then 1; no mem_rd during HOLD.
REQ-035 halt_dec with instr_valid -> HALTED, dump pulse of exactly 1 cycle, no further mem_rd; rst recovers to IDLE.
REQ-036 With FETCH_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_done never -> err=1 after 4 WAIT cycles, HALTED, dump pulse; without macro -> err stays 0.
